regfile_wb_queue: RTL

- Write-back queue and sequencer directly upstream of the 2-bit register bank.
- Accepts write requests over a valid/ready handshake and buffers them in a small in-order FIFO.
- Issues one write per cycle as a one-hot register select plus write enable and data, which drive the bank's per-register select, write-enable and write-data inputs.
- Reports pending writes to a queried register address (read-after-write hazard) and flags out-of-range addresses.

---
 rtl/regfile_wb_queue.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/regfile_wb_queue.sv
// Write-back queue for the register bank: buffers write requests in an
// in-order FIFO and issues at most one registered write per cycle as a
// one-hot select, write enable and write data. Also reports read-after-write
// hazards against a queried address and latches out-of-range requests.
//
// Handshake: a request transfers at a rising edge where req_valid and
// req_ready are both high; req_ready depends only on the current count, and
// the requester must hold addr/data stable while req_valid is high and
// req_ready is low.
module regfile_wb_queue #(
  parameter int NREG  = 4,
  parameter int AW    = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [AW-1:0]              req_addr,
  input  logic [1:0]                 req_data,
  input  logic                       hold,
  output logic [NREG-1:0]            chosen,
  output logic                       w_en,
  output logic [1:0]                 w_data,
  input  logic [AW-1:0]              rd_addr,
  output logic                       rd_pending,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err,
  output logic [1:0]                 state_dbg
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW:0]   NREG_C  = (AW+1)'(NREG);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t state, state_next;

  logic [AW-1:0] addr_mem [DEPTH];
  logic [1:0]    data_mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;

  logic          accept, in_range, push, pop;
  logic [CW-1:0] count_next;

  // Handshake and push/pop decisions; issue depends only on count and hold.
  always_comb begin
    req_ready  = (count < DEPTH_C);
    accept     = req_valid & req_ready;
    in_range   = ({1'b0, req_addr} < NREG_C);
    push       = accept & in_range;
    pop        = (count != '0) & ~hold;
    count_next = count + CW'(push) - CW'(pop);
  end

  // FIFO storage, pointers and occupancy; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        addr_mem[wr_ptr] <= req_addr;
        data_mem[wr_ptr] <= req_data;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count_next;
    end
  end

  // Registered write port toward the bank; w_data keeps its last value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chosen <= '0;
      w_en   <= 1'b0;
      w_data <= '0;
    end else if (pop) begin
      chosen <= NREG'(1) << addr_mem[rd_ptr];
      w_en   <= 1'b1;
      w_data <= data_mem[rd_ptr];
    end else begin
      chosen <= '0;
      w_en   <= 1'b0;
    end
  end

  // Sticky flag for requests addressed beyond the bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (accept && !in_range) begin
      err <= 1'b1;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Sequencer next state: tracks whether the queue is draining or stalled.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (count_next != '0) state_next = ISSUE;
      end
      ISSUE: begin
        if (count_next == '0) state_next = IDLE;
        else if (hold)        state_next = STALL;
      end
      STALL: begin
        if (count_next == '0) state_next = IDLE;
        else if (!hold)       state_next = ISSUE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign state_dbg = state;

  // Hazard check: any live FIFO entry or the write currently on the bus.
  logic [(2**AW)-1:0] chosen_ext;
  logic [PW-1:0]      offs;

  always_comb begin
    chosen_ext = (2**AW)'(chosen);
    rd_pending = 1'b0;
    offs       = '0;
    if ({1'b0, rd_addr} < NREG_C) begin
      for (int i = 0; i < DEPTH; i++) begin
        offs = PW'(i) - rd_ptr;
        if (({1'b0, offs} < count) && (addr_mem[i] == rd_addr)) begin
          rd_pending = 1'b1;
        end
      end
      if (w_en && chosen_ext[rd_addr]) begin
        rd_pending = 1'b1;
      end
    end
  end

endmodule
